serial_sub_unit: RTL and testbench



---
 rtl/serial_sub_unit_pkg.sv | 26 ++
 rtl/serial_sub_unit_digit.sv | 30 +++
 rtl/serial_sub_unit.sv | 131 +++++++++++++
 tb/tb_serial_sub_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_unit_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: FSM states,
// operation codes and the signed-overflow helper.
package serial_sub_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Operand signs come from the latched operands only; the borrow/carry in never affects them
    function automatic logic calc_overflow(input logic op_f, input logic a_msb,
                                           input logic b_msb, input logic r_msb);
        logic ovf;
        if (op_f == OP_ADD) begin
            ovf = (a_msb == b_msb) && (r_msb != a_msb);
        end else begin
            ovf = (a_msb != b_msb) && (r_msb != a_msb);
        end
        return ovf;
    endfunction

endpackage

// File: rtl/serial_sub_unit_digit.sv
// One DIGIT-wide add/subtract slice with borrow/carry in and out.
module sub_digit
    import serial_sub_unit_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    input  logic             op,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] ext_s;

    // Extended-width arithmetic: the extra MSB is the carry (add) or borrow (sub)
    always_comb begin
        ext_s = '0;
        if (op == OP_ADD) begin
            ext_s = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, bin};
        end else begin
            ext_s = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
        end
    end

    assign d    = ext_s[DIGIT-1:0];
    assign bout = ext_s[DIGIT];

endmodule

// File: rtl/serial_sub_unit.sv
// Digit-serial WIDTH-bit add/subtract engine with start/done handshake and
// status flags; one DIGIT slice is processed per clock.
module serial_sub_unit
    import serial_sub_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r, b_r, result_r, result_s;
    logic             op_r, borrow_r;
    logic             busy_r, done_r, borrow_out_r, overflow_r, zero_r;
    logic [DIGIT-1:0] x_s, y_s, d_s;
    logic             bout_s;

    assign x_s = a_r[cnt_r*DIGIT +: DIGIT];
    assign y_s = b_r[cnt_r*DIGIT +: DIGIT];

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (x_s),
        .y    (y_s),
        .bin  (borrow_r),
        .op   (op_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Result with the current digit merged in; on the last step this is the final value
    always_comb begin
        result_s = result_r;
        result_s[cnt_r*DIGIT +: DIGIT] = d_s;
    end

    // State, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            cnt_r        <= '0;
            a_r          <= '0;
            b_r          <= '0;
            op_r         <= 1'b0;
            borrow_r     <= 1'b0;
            result_r     <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            borrow_out_r <= 1'b0;
            overflow_r   <= 1'b0;
            zero_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != S_IDLE);
            done_r  <= (state_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        op_r     <= op;
                        borrow_r <= borrow_in;
                        cnt_r    <= '0;
                        result_r <= '0;
                    end
                end
                S_RUN: begin
                    result_r <= result_s;
                    borrow_r <= bout_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == LAST_CNT) begin
                        borrow_out_r <= bout_s;
                        overflow_r   <= calc_overflow(op_r, a_r[WIDTH-1], b_r[WIDTH-1],
                                                      result_s[WIDTH-1]);
                        zero_r       <= (result_s == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign result     = result_r;
    assign borrow_out = borrow_out_r;
    assign overflow   = overflow_r;
    assign zero       = zero_r;

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed scoreboard bench running three serial_sub_unit instances side by
// side (DIGIT = 4, 1 and 32) on the same operand stream.
module tb_serial_sub_unit;

    typedef struct packed {
        logic [31:0] r;
        logic        bo;
        logic        ov;
        logic        z;
    } exp_t;

    localparam int ST [3] = '{8, 32, 1};

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        start_v;
    logic              op;
    logic              bin;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [2:0]        busy_v, done_v, bo_v, ov_v, z_v;
    logic [2:0][31:0]  res_v;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    serial_sub_unit #(.WIDTH(32), .DIGIT(4)) u_d4 (
        .clk(clk), .reset(reset), .start(start_v[0]), .op(op), .a(a), .b(b),
        .borrow_in(bin), .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]),
        .borrow_out(bo_v[0]), .overflow(ov_v[0]), .zero(z_v[0])
    );

    serial_sub_unit #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .op(op), .a(a), .b(b),
        .borrow_in(bin), .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]),
        .borrow_out(bo_v[1]), .overflow(ov_v[1]), .zero(z_v[1])
    );

    serial_sub_unit #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .clk(clk), .reset(reset), .start(start_v[2]), .op(op), .a(a), .b(b),
        .borrow_in(bin), .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]),
        .borrow_out(bo_v[2]), .overflow(ov_v[2]), .zero(z_v[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_one(input int g, input exp_t e);
        case (g)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_one(input int g, output exp_t e);
        int sz;
        e = '0;
        case (g)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        chk($sformatf("sb_avail%0d", g), 64'(sz > 0), 64'd1);
        if (sz > 0) begin
            case (g)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
        end
    endtask

    // One operation on all three instances; hold keeps start high through RUN and
    // scrambles the inputs, b2b re-starts each instance in the cycle after its done.
    task automatic run_op(input string tag, input logic o, input logic [31:0] av,
                          input logic [31:0] bv, input logic bi, input logic [31:0] er,
                          input logic ebo, input logic eov, input bit hold, input bit b2b);
        exp_t e;
        exp_t got;
        int   dcnt [3];
        int   bcnt [3];
        e = '{r: er, bo: ebo, ov: eov, z: (er == 32'd0)};
        op = o; a = av; b = bv; bin = bi;
        start_v = 3'b111;
        for (int g = 0; g < 3; g++) begin
            push_one(g, e);
            dcnt[g] = 0;
            bcnt[g] = 0;
        end
        tick();
        for (int n = 0; n <= 70; n++) begin
            if (n > 0) tick();
            for (int g = 0; g < 3; g++) begin
                if (busy_v[g]) bcnt[g]++;
                if (done_v[g]) begin
                    chk($sformatf("%s/lat%0d", tag, g), 64'(n),
                        64'((dcnt[g] == 0) ? ST[g] : 2 * ST[g] + 2));
                    pop_one(g, got);
                    chk($sformatf("%s/res%0d", tag, g), 64'(res_v[g]), 64'(got.r));
                    chk($sformatf("%s/flags%0d", tag, g),
                        64'({bo_v[g], ov_v[g], z_v[g]}), 64'({got.bo, got.ov, got.z}));
                    dcnt[g]++;
                end
                start_v[g] = (hold && n < ST[g]) || (b2b && n == ST[g] + 1);
                if (b2b && n == ST[g] + 1) push_one(g, e);
            end
            if (hold && n == 1) begin
                a = ~av; b = 32'h1234_5678; op = ~o; bin = ~bi;
            end
        end
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s/ndone%0d", tag, g), 64'(dcnt[g]), 64'(b2b ? 2 : 1));
            chk($sformatf("%s/nbusy%0d", tag, g), 64'(bcnt[g]),
                64'((b2b ? 2 : 1) * (ST[g] + 1)));
        end
    endtask

    initial begin
        reset = 1'b1; start_v = 3'b000; op = 1'b0; a = 32'd0; b = 32'd0; bin = 1'b0;
        tick();
        start_v = 3'b111;
        tick();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_ctl%0d", g),
                64'({busy_v[g], done_v[g], bo_v[g], ov_v[g], z_v[g]}), 64'd0);
            chk($sformatf("rst_res%0d", g), 64'(res_v[g]), 64'd0);
        end
        start_v = 3'b000;
        reset = 1'b0;
        tick();
        chk("idle_after_rst", 64'({busy_v, done_v}), 64'd0);

        run_op("sub_5_3",   1'b0, 32'd5,          32'd3,          1'b0, 32'd2,          1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub_0_1",   1'b0, 32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0, 1'b0);
        run_op("sub_7_7b",  1'b0, 32'd7,          32'd7,          1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",   1'b0, 32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0, 1'b0);
        run_op("add_ovf",   1'b1, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  1'b0, 1'b1, 1'b0, 1'b0);
        run_op("add_wrap",  1'b1, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          1'b1, 1'b0, 1'b0, 1'b0);
        run_op("add_cin",   1'b1, 32'h1234_5678,  32'h0F0F_0F0F,  1'b1, 32'h2143_6588,  1'b0, 1'b0, 1'b0, 1'b0);
        run_op("hold",      1'b0, 32'h0000_1000,  32'd1,          1'b0, 32'h0000_0FFF,  1'b0, 1'b0, 1'b1, 1'b0);
        run_op("b2b",       1'b0, 32'd100,        32'd58,         1'b0, 32'd42,         1'b0, 1'b0, 1'b0, 1'b1);

        a = 32'd9; b = 32'd3; op = 1'b0; bin = 1'b0;
        tick();
        chk("idle_hold_res", 64'(res_v[0]), 64'd42);

        // Abort the DIGIT=4 and DIGIT=1 instances partway through RUN
        start_v = 3'b011;
        tick();
        start_v = 3'b000;
        tick();
        tick();
        chk("pre_rst_busy", 64'(busy_v[1:0]), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ctl", 64'({busy_v, done_v}), 64'd0);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("mid_rst_res%0d", g), 64'(res_v[g]), 64'd0);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("mid_rst_nodone", 64'(done_v), 64'd0);
        end

        run_op("after_rst", 1'b0, 32'd9, 32'd3, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);

        chk("sb_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
